wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline write-back
//  path and the multi-cycle MMM accelerator result stream. Pipeline writes always win.
//  Accelerator results are buffered in a FIFO and drained into idle write-port cycles.
//  Exports a pending-rd mask so decode can hold dependent instructions.
// PARAMETERS
//  WIDTH        32  register data width
//  DEPTH        4   accelerator result FIFO entries (power of 2, >=2)
//  STARVE_LIM   8   consecutive blocked drain cycles before stall_req asserts (>=1)
// PORTS
//  clk             in   1      clock
//  rst             in   1      synchronous, active-high reset
//  pipe_wr_en      in   1      pipeline write-back request this cycle
//  pipe_rd         in   5      pipeline destination register
//  pipe_wr_data    in   WIDTH  pipeline write data
//  acc_valid       in   1      accelerator result valid
//  acc_ready       out  1      arbiter accepts result (handshake on valid&&ready)
//  acc_rd          in   5      accelerator destination register
//  acc_data        in   WIDTH  accelerator result data
//  reg_wr_en_WBID  out  1      register-file write enable
//  rd_WBID         out  5      register-file write address
//  reg_wr_data_WBID out WIDTH  register-file write data
//  pend_mask       out  32     bit r set while a result for xr is queued
//  stall_req       out  1      request hazard unit to insert a WB bubble
//  fifo_count      out  $clog2(DEPTH)+1  current FIFO occupancy
//  waw_err         out  1      sticky: pipeline wrote a register with pend_mask bit set
// BEHAVIOUR
//  Reset: FIFO empty, fifo_count=0, pend_mask=0, stall_req=0, waw_err=0, starve cnt=0.
//   Write-port outputs combinational; with pipe_wr_en=0 and FIFO empty they are 0.
//  Write-port mux (combinational, same cycle):
//   pipe_wr_en=1 -> port carries pipe_rd/pipe_wr_data, FIFO not popped.
//   pipe_wr_en=0, FIFO non-empty -> port carries FIFO head; head popped at clock edge.
//   else port idle (en=0, rd=0, data=0).
//  acc_ready = !full && !pend_mask[acc_rd] (duplicate pending rd refused, preserves WAW).
//   acc_ready=1 for acc_rd=0; such results are accepted and discarded (no enqueue, no mask).
//  Enqueue on acc_valid&&acc_ready&&acc_rd!=0: push {rd,data}, set pend_mask[rd] next cycle.
//  Pop: clears pend_mask[head rd] next cycle. Push and pop same cycle: count unchanged,
//   full FIFO cannot push even if popping (acc_ready depends on registered full only).
//  Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
//  Starvation FSM: IDLE -> (FIFO non-empty && pipe_wr_en) count blocked cycles;
//   cnt reaches STARVE_LIM -> STALL (stall_req=1). STALL -> IDLE on first pop; cnt clears
//   on any pop or when FIFO empty. stall_req registered, asserts cycle after limit reached.
//  waw_err set when pipe_wr_en && pipe_rd!=0 && pend_mask[pipe_rd]; cleared only by rst.
//  Pipeline write to x0 still occupies the port (no FIFO drain that cycle).
//  rst mid-operation discards all queued results; accelerator must reissue.
// CONFIGURATION
//  WB_ACC_BYPASS_EN defined: if FIFO empty, pipe_wr_en=0 and acc handshake occurs with
//   acc_rd!=0, result goes to write port same cycle, never enqueued, pend_mask untouched.
//  Not defined: every accepted result is enqueued; earliest write is the cycle after accept.
// TESTING
//  acc result x5=0xDEADBEEF, pipe idle -> enqueued, pend_mask[5]=1, port writes next cycle
//   (same cycle with WB_ACC_BYPASS_EN), then pend_mask[5]=0.
//  pipe_wr_en held 1, four acc results to x1..x4 (DEPTH=4) -> fifo_count=4, acc_ready=0,
//   stall_req=1 after STARVE_LIM=8 blocked cycles; pipe bubble -> x1 written, stall_req drops.
//  acc_rd=7 while x7 pending -> acc_ready=0 until x7 drains; then accepted.
//  acc_rd=0 valid -> acc_ready=1, no enqueue, fifo_count unchanged, port untouched.
//  pipe writes x9 while pend_mask[9]=1 -> waw_err=1 next cycle, sticky until rst.
//  rst asserted with fifo_count=3 -> next cycle count=0, pend_mask=0, stall_req=0.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - write-back port arbiter bus bundle
interface wb_port_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             pipe_wr_en;
    logic [4:0]       pipe_rd;
    logic [WIDTH-1:0] pipe_wr_data;
    logic             acc_valid;
    logic             acc_ready;
    logic [4:0]       acc_rd;
    logic [WIDTH-1:0] acc_data;
    logic             reg_wr_en_WBID;
    logic [4:0]       rd_WBID;
    logic [WIDTH-1:0] reg_wr_data_WBID;
    logic [31:0]      pend_mask;
    logic             stall_req;
    logic [CW-1:0]    fifo_count;
    logic             waw_err;

    modport master (
        output pipe_wr_en, pipe_rd, pipe_wr_data, acc_valid, acc_rd, acc_data,
        input  acc_ready, reg_wr_en_WBID, rd_WBID, reg_wr_data_WBID,
        input  pend_mask, stall_req, fifo_count, waw_err
    );

    modport slave (
        input  pipe_wr_en, pipe_rd, pipe_wr_data, acc_valid, acc_rd, acc_data,
        output acc_ready, reg_wr_en_WBID, rd_WBID, reg_wr_data_WBID,
        output pend_mask, stall_req, fifo_count, waw_err
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter (optional WB_ACC_BYPASS_EN)
module wb_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    wb_port_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    typedef enum logic {ST_IDLE, ST_STALL} state_t;

    logic [4:0]       fifo_rd_q   [DEPTH];
    logic [WIDTH-1:0] fifo_data_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [31:0]      pend_mask_q, pend_mask_d;
    logic             waw_err_q, waw_err_d;
    state_t           state_q;
    logic [SW-1:0]    starve_cnt_q;
    logic             stall_req_q;

    logic             fifo_empty, fifo_full;
    logic             acc_ready, acc_fire, bypass, push, pop, blocked;
    logic [4:0]       head_rd;
    logic [WIDTH-1:0] head_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign head_rd    = fifo_rd_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];

    // x0 results are always taken and dropped; a pending rd is refused to keep WAW order
    assign acc_ready = (bus.acc_rd == 5'd0) || (!fifo_full && !pend_mask_q[bus.acc_rd]);
    assign acc_fire  = bus.acc_valid && acc_ready && (bus.acc_rd != 5'd0);

`ifdef WB_ACC_BYPASS_EN
    assign bypass = acc_fire && fifo_empty && !bus.pipe_wr_en;
`else
    assign bypass = 1'b0;
`endif

    assign push    = acc_fire && !bypass;
    assign pop     = !bus.pipe_wr_en && !fifo_empty;
    assign blocked = bus.pipe_wr_en && !fifo_empty;

    // Write-port mux: pipeline first, then FIFO head, then (optionally) a bypassed result
    always_comb begin
        bus.reg_wr_en_WBID   = 1'b0;
        bus.rd_WBID          = 5'd0;
        bus.reg_wr_data_WBID = '0;
        if (bus.pipe_wr_en) begin
            bus.reg_wr_en_WBID   = 1'b1;
            bus.rd_WBID          = bus.pipe_rd;
            bus.reg_wr_data_WBID = bus.pipe_wr_data;
        end else if (!fifo_empty) begin
            bus.reg_wr_en_WBID   = 1'b1;
            bus.rd_WBID          = head_rd;
            bus.reg_wr_data_WBID = head_data;
        end else if (bypass) begin
            bus.reg_wr_en_WBID   = 1'b1;
            bus.rd_WBID          = bus.acc_rd;
            bus.reg_wr_data_WBID = bus.acc_data;
        end
    end

    // Next-state for pointers, occupancy, pending mask and the sticky WAW flag
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pend_mask_d = pend_mask_q;
        waw_err_d   = waw_err_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // head rd and incoming rd never collide: the incoming one would have been refused
        if (pop)  pend_mask_d[head_rd]    = 1'b0;
        if (push) pend_mask_d[bus.acc_rd] = 1'b1;
        if (bus.pipe_wr_en && (bus.pipe_rd != 5'd0) && pend_mask_q[bus.pipe_rd])
            waw_err_d = 1'b1;
    end

    // Result storage; contents are meaningless while the matching count slot is empty
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= bus.acc_rd;
            fifo_data_q[wr_ptr_q] <= bus.acc_data;
        end
    end

    // Control state registers; reset discards every queued result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pend_mask_q <= '0;
            waw_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pend_mask_q <= pend_mask_d;
            waw_err_q   <= waw_err_d;
        end
    end

    // Starvation FSM: request a WB bubble once the queue has been blocked STARVE_LIM cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            stall_req_q  <= 1'b0;
        end else begin
            if (pop || fifo_empty)
                starve_cnt_q <= '0;
            else if (blocked && (starve_cnt_q != SW'(STARVE_LIM)))
                starve_cnt_q <= starve_cnt_q + SW'(1);
            case (state_q)
                ST_IDLE: begin
                    if (blocked && (starve_cnt_q == SW'(STARVE_LIM - 1))) begin
                        state_q     <= ST_STALL;
                        stall_req_q <= 1'b1;
                    end
                end
                ST_STALL: begin
                    if (pop || fifo_empty) begin
                        state_q     <= ST_IDLE;
                        stall_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    stall_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.acc_ready  = acc_ready;
    assign bus.pend_mask  = pend_mask_q;
    assign bus.stall_req  = stall_req_q;
    assign bus.fifo_count = count_q;
    assign bus.waw_err    = waw_err_q;
endmodule
